// File: rtl/i2s_apb_streamer_if.sv
// i2s_apb_streamer_if
//   Groups the streamer's three buses:
//     - tx stream  : tx_valid / tx_ready / tx_data    (samples towards the I2S transmitter)
//     - rx stream  : rx_valid / rx_ready / rx_data    (samples drained from the I2S receiver)
//     - APB master : psel / penable / pwrite / paddr / pwdata / prdata
//   master : the view used by i2s_apb_streamer
//   slave  : the view of whatever surrounds it (stream producer/consumer, APB slave)
interface i2s_apb_streamer_if;
   logic        tx_valid;
   logic        tx_ready;
   logic [31:0] tx_data;

   logic        rx_valid;
   logic        rx_ready;
   logic [31:0] rx_data;

   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;

   modport master (
      input  tx_valid, tx_data, rx_ready, prdata,
      output tx_ready, rx_valid, rx_data,
      output psel, penable, pwrite, paddr, pwdata
   );

   modport slave (
      output tx_valid, tx_data, rx_ready, prdata,
      input  tx_ready, rx_valid, rx_data,
      input  psel, penable, pwrite, paddr, pwdata
   );
endinterface

// File: rtl/i2s_apb_streamer.sv
// i2s_apb_streamer
//   APB master that moves tx stream samples into the I2S Tx FIFO data register
//   and drains the I2S Rx FIFO data register into a one-entry rx stream buffer.
//   One APB transfer (SETUP + ACCESS, no wait states) at a time; when both
//   directions are pending the one not served last wins.
// Ports
//   pclk, preset   : clock, asynchronous active-high reset
//   en             : streaming enable, only looked at when idle
//   txfifo_full    : Tx FIFO of the transmitting I2S_top is full
//   rxfifo_empty   : Rx FIFO of the receiving I2S_top is empty
//   tx_count       : completed APB writes (wraps)
//   rx_count       : completed APB reads (wraps)
//   bus            : tx stream, rx stream and APB master signals
module i2s_apb_streamer #(
   parameter logic [31:0] TX_ADDR = 32'h4,
   parameter logic [31:0] RX_ADDR = 32'h18
) (
   input  logic                      pclk,
   input  logic                      preset,
   input  logic                      en,
   input  logic                      txfifo_full,
   input  logic                      rxfifo_empty,
   output logic [15:0]               tx_count,
   output logic [15:0]               rx_count,
   i2s_apb_streamer_if.master        bus
);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;
   typedef enum logic {DIR_TX, DIR_RX} dir_t;

   state_t      r_state;
   state_t      w_state_nxt;
   dir_t        r_last_dir;
   logic        r_pwrite;
   logic [31:0] r_paddr;
   logic [31:0] r_pwdata;
   logic [31:0] r_rx_data;
   logic        r_rx_valid;
   logic [15:0] r_tx_count;
   logic [15:0] r_rx_count;

   logic        w_tx_pend;
   logic        w_rx_pend;
   logic        w_grant_tx;
   logic        w_grant_rx;

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // An RX read is only started while the output buffer is empty, so a
   // completed read can never overwrite an unconsumed word.
   always_comb begin
      w_state_nxt = r_state;
      w_grant_tx  = 1'b0;
      w_grant_rx  = 1'b0;
      w_tx_pend   = en & bus.tx_valid & ~txfifo_full;
      w_rx_pend   = en & ~rxfifo_empty & ~r_rx_valid;
      case (r_state)
         S_IDLE: begin
            if (w_tx_pend && (!w_rx_pend || r_last_dir == DIR_RX)) begin
               w_grant_tx  = 1'b1;
               w_state_nxt = S_SETUP;
            end else if (w_rx_pend) begin
               w_grant_rx  = 1'b1;
               w_state_nxt = S_SETUP;
            end
         end
         S_SETUP:  w_state_nxt = S_ACCESS;
         S_ACCESS: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         r_last_dir <= DIR_RX;
         r_pwrite   <= 1'b0;
         r_paddr    <= '0;
         r_pwdata   <= '0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
         r_tx_count <= '0;
         r_rx_count <= '0;
      end else begin
         if (r_rx_valid && bus.rx_ready) begin
            r_rx_valid <= 1'b0;
         end
         if (w_grant_tx) begin
            r_last_dir <= DIR_TX;
            r_pwrite   <= 1'b1;
            r_paddr    <= TX_ADDR;
            r_pwdata   <= bus.tx_data;
         end else if (w_grant_rx) begin
            r_last_dir <= DIR_RX;
            r_pwrite   <= 1'b0;
            r_paddr    <= RX_ADDR;
         end
         if (r_state == S_ACCESS) begin
            if (r_pwrite) begin
               r_tx_count <= r_tx_count + 16'd1;
            end else begin
               r_rx_data  <= bus.prdata;
               r_rx_valid <= 1'b1;
               r_rx_count <= r_rx_count + 16'd1;
            end
         end
      end
   end

   // tx_ready is the grant itself; masked during reset so no sample is
   // accepted while the grant is being thrown away.
   assign bus.tx_ready = w_grant_tx & ~preset;
   assign bus.psel     = (r_state != S_IDLE);
   assign bus.penable  = (r_state == S_ACCESS);
   assign bus.pwrite   = r_pwrite;
   assign bus.paddr    = r_paddr;
   assign bus.pwdata   = r_pwdata;
   assign bus.rx_valid = r_rx_valid;
   assign bus.rx_data  = r_rx_data;
   assign tx_count     = r_tx_count;
   assign rx_count     = r_rx_count;

endmodule

// File: tb/tb_i2s_apb_streamer.sv
// tb_i2s_apb_streamer
//   Directed scenarios plus a randomized loopback through two FIFO models
//   standing in for the I2S transmitter/receiver pair. A transaction-level
//   model predicts every DUT output on every cycle.
module tb_i2s_apb_streamer;

   logic        pclk = 1'b0;
   logic        preset;
   logic        en;
   logic        txfifo_full;
   logic        rxfifo_empty;
   logic [15:0] tx_count;
   logic [15:0] rx_count;

   i2s_apb_streamer_if bus_if ();

   i2s_apb_streamer #(
      .TX_ADDR (32'h4),
      .RX_ADDR (32'h18)
   ) dut (
      .pclk         (pclk),
      .preset       (preset),
      .en           (en),
      .txfifo_full  (txfifo_full),
      .rxfifo_empty (rxfifo_empty),
      .tx_count     (tx_count),
      .rx_count     (rx_count),
      .bus          (bus_if.master)
   );

   always #5 pclk = ~pclk;

   int n_checks = 0;
   int n_fail   = 0;

   // Values the next cycle should present; applied at the falling edge.
   logic        s_preset, s_en, s_tx_valid, s_rx_ready, s_txfifo_full, s_rxfifo_empty;
   logic [31:0] s_tx_data, s_prdata;

   // Loopback environment: I2S Tx FIFO, I2S Rx FIFO, words accepted in order.
   bit          env_mode;
   logic [31:0] txq[$];
   logic [31:0] rxq[$];
   logic [31:0] expq[$];
   int          sent, recvd;
   localparam int unsigned FIFO_DEPTH = 4;

   // Transaction-level model: phase counts cycles into the current transfer
   // (0 = no transfer), plus the architectural registers the outputs expose.
   int          m_phase;
   bit          m_last_tx;
   bit          m_pwrite;
   bit          m_rx_valid;
   logic [31:0] m_paddr, m_pwdata, m_rx_data;
   logic [15:0] m_txc, m_rxc;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase    = 0;
      m_last_tx  = 1'b0;
      m_pwrite   = 1'b0;
      m_rx_valid = 1'b0;
      m_paddr    = '0;
      m_pwdata   = '0;
      m_rx_data  = '0;
      m_txc      = '0;
      m_rxc      = '0;
   endtask

   function automatic bit want_tx();
      return en && bus_if.tx_valid && !txfifo_full;
   endfunction

   function automatic bit want_rx();
      return en && !rxfifo_empty && !m_rx_valid;
   endfunction

   function automatic bit exp_grant_tx();
      return (m_phase == 0) && want_tx() && (!want_rx() || !m_last_tx);
   endfunction

   function automatic bit exp_grant_rx();
      return (m_phase == 0) && want_rx() && !exp_grant_tx();
   endfunction

   task automatic drive();
      preset            = s_preset;
      en                = s_en;
      bus_if.tx_valid   = s_tx_valid;
      bus_if.tx_data    = s_tx_data;
      bus_if.rx_ready   = s_rx_ready;
      if (env_mode) begin
         txfifo_full    = (txq.size() >= FIFO_DEPTH);
         rxfifo_empty   = (rxq.size() == 0);
         bus_if.prdata  = (rxq.size() != 0) ? rxq[0] : 32'h0;
      end else begin
         txfifo_full    = s_txfifo_full;
         rxfifo_empty   = s_rxfifo_empty;
         bus_if.prdata  = s_prdata;
      end
   endtask

   task automatic check();
      cmp("tx_ready", 32'(bus_if.tx_ready), 32'(!preset && exp_grant_tx()));
      cmp("psel",     32'(bus_if.psel),     32'(m_phase != 0));
      cmp("penable",  32'(bus_if.penable),  32'(m_phase == 2));
      cmp("pwrite",   32'(bus_if.pwrite),   32'(m_pwrite));
      cmp("paddr",    bus_if.paddr,         m_paddr);
      cmp("pwdata",   bus_if.pwdata,        m_pwdata);
      cmp("rx_valid", 32'(bus_if.rx_valid), 32'(m_rx_valid));
      cmp("rx_data",  bus_if.rx_data,       m_rx_data);
      cmp("tx_count", 32'(tx_count),        32'(m_txc));
      cmp("rx_count", 32'(rx_count),        32'(m_rxc));
   endtask

   // Advance the model across the coming rising edge.
   task automatic model_step();
      bit          gt, gr;
      logic [31:0] w;
      if (preset) begin
         model_reset();
         return;
      end
      gt = exp_grant_tx();
      gr = exp_grant_rx();
      if (m_rx_valid && bus_if.rx_ready) begin
         m_rx_valid = 1'b0;
         if (env_mode) begin
            if (expq.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL stream_extra: got %h expected no word at %0t", bus_if.rx_data, $time);
            end else begin
               w = expq.pop_front();
               cmp("stream_order", bus_if.rx_data, w);
               recvd++;
            end
         end
      end
      if (m_phase == 0) begin
         if (gt) begin
            m_phase   = 1;
            m_last_tx = 1'b1;
            m_pwrite  = 1'b1;
            m_paddr   = 32'h4;
            m_pwdata  = bus_if.tx_data;
            if (env_mode) begin
               expq.push_back(bus_if.tx_data);
               sent++;
            end
         end else if (gr) begin
            m_phase   = 1;
            m_last_tx = 1'b0;
            m_pwrite  = 1'b0;
            m_paddr   = 32'h18;
         end
      end else if (m_phase == 1) begin
         m_phase = 2;
      end else begin
         m_phase = 0;
         if (m_pwrite) begin
            m_txc++;
            if (env_mode) txq.push_back(m_pwdata);
         end else begin
            m_rx_valid = 1'b1;
            m_rx_data  = bus_if.prdata;
            m_rxc++;
            if (env_mode) w = rxq.pop_front();
         end
      end
      // Serial link between the two I2S instances moves words at its own pace.
      if (env_mode && txq.size() != 0 && rxq.size() < FIFO_DEPTH && $urandom_range(0, 2) == 0) begin
         w = txq.pop_front();
         rxq.push_back(w);
      end
   endtask

   task automatic cycle();
      @(negedge pclk);
      drive();
      #1;
      check();
      model_step();
   endtask

   task automatic do_reset();
      s_preset       = 1'b1;
      s_en           = 1'b0;
      s_tx_valid     = 1'b0;
      s_tx_data      = '0;
      s_rx_ready     = 1'b0;
      s_txfifo_full  = 1'b0;
      s_rxfifo_empty = 1'b1;
      s_prdata       = '0;
      env_mode       = 1'b0;
      txq.delete();
      rxq.delete();
      expq.delete();
      sent  = 0;
      recvd = 0;
      model_reset();
      repeat (2) cycle();
      s_preset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected $finish at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      preset = 1'b1;
      en = 1'b0; txfifo_full = 1'b0; rxfifo_empty = 1'b1;
      bus_if.tx_valid = 1'b0; bus_if.tx_data = '0; bus_if.rx_ready = 1'b0; bus_if.prdata = '0;

      // Reset state and single write.
      do_reset();
      cycle();
      cmp("rst_paddr", bus_if.paddr, 32'h0);
      cmp("rst_rx_valid", 32'(bus_if.rx_valid), 32'h0);
      cmp("rst_tx_count", 32'(tx_count), 32'h0);
      s_en = 1'b1; s_tx_valid = 1'b1; s_tx_data = 32'hDEADBEEF;
      cycle();
      cmp("wr_tx_ready", 32'(bus_if.tx_ready), 32'h1);
      s_tx_valid = 1'b0;
      cycle();
      cmp("wr_setup_psel", 32'(bus_if.psel), 32'h1);
      cmp("wr_setup_penable", 32'(bus_if.penable), 32'h0);
      cmp("wr_paddr", bus_if.paddr, 32'h4);
      cmp("wr_pwdata", bus_if.pwdata, 32'hDEADBEEF);
      cycle();
      cmp("wr_access_penable", 32'(bus_if.penable), 32'h1);
      cycle();
      cmp("wr_tx_count", 32'(tx_count), 32'h1);

      // Single read held in the buffer until consumed.
      do_reset();
      s_en = 1'b1; s_rxfifo_empty = 1'b0; s_prdata = 32'h12345678;
      cycle();
      cycle();
      cmp("rd_paddr", bus_if.paddr, 32'h18);
      cmp("rd_pwrite", 32'(bus_if.pwrite), 32'h0);
      cycle();
      cycle();
      cmp("rd_rx_valid", 32'(bus_if.rx_valid), 32'h1);
      cmp("rd_rx_data", bus_if.rx_data, 32'h12345678);
      repeat (4) cycle();
      cmp("rd_hold_psel", 32'(bus_if.psel), 32'h0);
      cmp("rd_hold_count", 32'(rx_count), 32'h1);
      s_rx_ready = 1'b1; s_prdata = 32'hCAFEF00D;
      cycle();
      cycle();
      cmp("rd_cleared", 32'(bus_if.rx_valid), 32'h0);
      s_rxfifo_empty = 1'b1; s_rx_ready = 1'b0;
      repeat (3) cycle();
      cmp("rd2_rx_data", bus_if.rx_data, 32'hCAFEF00D);
      cmp("rd2_rx_count", 32'(rx_count), 32'h2);

      // Both directions pending: TX, RX, TX, RX.
      do_reset();
      s_en = 1'b1; s_tx_valid = 1'b1; s_tx_data = $urandom;
      s_rxfifo_empty = 1'b0; s_rx_ready = 1'b1; s_prdata = $urandom;
      repeat (12) cycle();
      s_en = 1'b0;
      cycle();
      cmp("alt_tx_count", 32'(tx_count), 32'h2);
      cmp("alt_rx_count", 32'(rx_count), 32'h2);
      repeat (2) cycle();

      // Tx FIFO full blocks the write until released.
      do_reset();
      s_en = 1'b1; s_tx_valid = 1'b1; s_tx_data = 32'h0BADF00D; s_txfifo_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         cmp("full_tx_ready", 32'(bus_if.tx_ready), 32'h0);
         cmp("full_psel", 32'(bus_if.psel), 32'h0);
      end
      s_txfifo_full = 1'b0;
      cycle();
      cmp("unfull_tx_ready", 32'(bus_if.tx_ready), 32'h1);
      s_tx_valid = 1'b0;
      repeat (3) cycle();
      cmp("unfull_tx_count", 32'(tx_count), 32'h1);

      // Reset asserted during the ACCESS cycle of a write.
      do_reset();
      s_en = 1'b1; s_tx_valid = 1'b1; s_tx_data = 32'hA5A5A5A5;
      cycle();
      s_tx_valid = 1'b0;
      cycle();
      cycle();
      cmp("ar_in_access", 32'(bus_if.penable), 32'h1);
      preset = 1'b1; s_preset = 1'b1;
      #1;
      model_reset();
      cmp("ar_psel", 32'(bus_if.psel), 32'h0);
      cmp("ar_penable", 32'(bus_if.penable), 32'h0);
      cmp("ar_tx_count", 32'(tx_count), 32'h0);
      check();
      cycle();
      s_preset = 1'b0; s_en = 1'b0;
      cycle();
      cmp("ar_after_count", 32'(tx_count), 32'h0);
      cmp("ar_after_psel", 32'(bus_if.psel), 32'h0);

      // Randomized loopback of 256 words.
      do_reset();
      env_mode = 1'b1;
      for (int c = 0; c < 30000 && recvd < 256; c++) begin
         s_en       = ($urandom_range(0, 15) != 0);
         s_tx_valid = (sent < 256) && ($urandom_range(0, 9) < 7);
         s_tx_data  = $urandom;
         s_rx_ready = $urandom_range(0, 1);
         cycle();
      end
      s_en = 1'b0; s_tx_valid = 1'b0; s_rx_ready = 1'b0;
      cycle();
      cmp("loop_words", 32'(recvd), 32'd256);
      cmp("loop_tx_count", 32'(tx_count), 32'd256);
      cmp("loop_rx_count", 32'(rx_count), 32'd256);
      cmp("loop_leftover", 32'(expq.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
